// File: rtl/slice_stream_if.sv
// rtl/slice_stream_if.sv - element stream bundle for slice_stream (input side and output side)
interface slice_stream_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/slice_stream.sv
// rtl/slice_stream.sv - space-to-depth reorder of a channel-major frame through a full-frame buffer
module slice_stream #(
    parameter int W          = 4,
    parameter int H          = 4,
    parameter int K          = 3,
    parameter int S          = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    slice_stream_if.slave bus
);
    localparam int N  = W * H * K;
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    localparam logic [AW-1:0] ONE    = AW'(1);
    localparam logic [AW-1:0] LAST_A = AW'(N - 1);
    localparam logic [AW-1:0] W_A    = AW'(W);
    localparam logic [AW-1:0] S_A    = AW'(S);
    localparam logic [AW-1:0] WH_A   = AW'(W * H);
    localparam logic [AW-1:0] SM_A   = AW'(S - 1);
    localparam logic [AW-1:0] KM_A   = AW'(K - 1);
    localparam logic [AW-1:0] OYM_A  = AW'(H / S - 1);
    localparam logic [AW-1:0] OXM_A  = AW'(W / S - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [N];
    logic [AW-1:0]         wr_addr;

    // Read-side counters: quadrant row/col (q/S, q%S), channel, output row, output col.
    logic [AW-1:0]         qy, qx, c, oy, ox;
    logic                  issue_done;

    // Three-deep element pipeline: memory read register, output register, skid register.
    logic                  rd_v, rd_l;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  out_v, out_l;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  sk_v, sk_l;
    logic [DATA_WIDTH-1:0] sk_q;

    logic                  accept;
    logic                  wr_last;
    logic                  out_fire;
    logic                  at_end;
    logic                  issue;
    logic [1:0]            held;
    logic [1:0]            held_n;
    logic [AW-1:0]         rd_addr;

    assign bus.in_ready  = (state == FILL) && !rst;
    assign bus.out_valid = out_v && !rst;
    assign bus.out_last  = out_l && !rst;
    assign bus.out_data  = rst ? '0 : out_q;

    always_comb begin
        accept   = bus.in_valid && bus.in_ready;
        wr_last  = (wr_addr == LAST_A);
        out_fire = out_v && bus.out_ready;
        at_end   = (qy == SM_A) && (qx == SM_A) && (c == KM_A)
                   && (oy == OYM_A) && (ox == OXM_A);
        held     = {1'b0, out_v} + {1'b0, sk_v} + {1'b0, rd_v};
        held_n   = held - {1'b0, out_fire};
        rd_addr  = c * WH_A + (oy * S_A + qy) * W_A + ox * S_A + qx;
        // The first read is issued on the cycle the last input lands so data is out two cycles later.
        issue    = ((state == FILL) && accept && wr_last)
                   || ((state == DRAIN) && !issue_done && (held_n <= 2'd1));
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr] <= bus.in_data;
        end
        if (issue) begin
            rd_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            wr_addr    <= '0;
            qy         <= '0;
            qx         <= '0;
            c          <= '0;
            oy         <= '0;
            ox         <= '0;
            issue_done <= 1'b0;
            rd_v       <= 1'b0;
            rd_l       <= 1'b0;
            out_v      <= 1'b0;
            out_l      <= 1'b0;
            out_q      <= '0;
            sk_v       <= 1'b0;
            sk_l       <= 1'b0;
            sk_q       <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        if (wr_last) begin
                            wr_addr <= '0;
                            state   <= DRAIN;
                        end else begin
                            wr_addr <= wr_addr + ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire && out_l) begin
                        state      <= FILL;
                        issue_done <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase

            rd_v <= issue;
            rd_l <= issue && at_end;

            // Counters wrap back to zero after the final element, ready for the next frame.
            if (issue) begin
                if (at_end) begin
                    issue_done <= 1'b1;
                end
                if (ox == OXM_A) begin
                    ox <= '0;
                    if (oy == OYM_A) begin
                        oy <= '0;
                        if (c == KM_A) begin
                            c <= '0;
                            if (qx == SM_A) begin
                                qx <= '0;
                                if (qy == SM_A) begin
                                    qy <= '0;
                                end else begin
                                    qy <= qy + ONE;
                                end
                            end else begin
                                qx <= qx + ONE;
                            end
                        end else begin
                            c <= c + ONE;
                        end
                    end else begin
                        oy <= oy + ONE;
                    end
                end else begin
                    ox <= ox + ONE;
                end
            end

            // Read data must be captured the cycle it appears; the skid absorbs it during a stall.
            if (!out_v || bus.out_ready) begin
                if (sk_v) begin
                    out_v <= 1'b1;
                    out_q <= sk_q;
                    out_l <= sk_l;
                    sk_v  <= rd_v;
                    if (rd_v) begin
                        sk_q <= rd_q;
                        sk_l <= rd_l;
                    end
                end else if (rd_v) begin
                    out_v <= 1'b1;
                    out_q <= rd_q;
                    out_l <= rd_l;
                end else begin
                    out_v <= 1'b0;
                    out_l <= 1'b0;
                end
            end else if (rd_v) begin
                sk_v <= 1'b1;
                sk_q <= rd_q;
                sk_l <= rd_l;
            end
        end
    end
endmodule

// File: tb/tb_slice_stream.sv
// tb/tb_slice_stream.sv - self-checking bench for slice_stream (default and W8/H4/K2/S4 instances)
module tb_slice_stream;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int K  = 3;
    localparam int S  = 2;
    localparam int N  = W * H * K;
    localparam int W1 = 8;
    localparam int H1 = 4;
    localparam int K1 = 2;
    localparam int S1 = 4;
    localparam int N1 = W1 * H1 * K1;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    slice_stream_if #(.DATA_WIDTH(DW)) b0 ();
    slice_stream_if #(.DATA_WIDTH(DW)) b1 ();

    slice_stream #(.W(W), .H(H), .K(K), .S(S), .DATA_WIDTH(DW)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    slice_stream #(.W(W1), .H(H1), .K(K1), .S(S1), .DATA_WIDTH(DW)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Input index feeding output position i, straight from the reorder definition.
    function automatic int map_idx(input int i, input int w, input int h, input int k, input int s);
        int per_ch, oc, r, oy, ox, q, ch;
        per_ch = (w / s) * (h / s);
        oc     = i / per_ch;
        r      = i % per_ch;
        oy     = r / (w / s);
        ox     = r % (w / s);
        q      = oc / k;
        ch     = oc % k;
        return ch * w * h + (oy * s + q / s) * w + ox * s + q % s;
    endfunction

    int          in_cnt = 0;
    int          out_idx = 0;
    int          frames = 0;
    int          last_cyc = -10;
    int          run = 0;
    int          last_run = 0;
    int          frame [N];
    int          got [$];
    logic        stall_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;
    logic        last_prev = 1'b0;
    int          idx1 = 0;
    int          frames1 = 0;
    int          got1 [$];
    int          ready_mode = 0;

    always @(negedge clk) begin : mon0
        bit draining;
        if (rst) begin
            chk("rst_in_ready", b0.in_ready, 0);
            chk("rst_out_valid", b0.out_valid, 0);
            chk("rst_out_last", b0.out_last, 0);
            chk("rst_out_data", b0.out_data, 0);
            in_cnt     = 0;
            out_idx    = 0;
            stall_prev = 1'b0;
            run        = 0;
        end else begin
            draining = (in_cnt == N);
            chk("in_ready", b0.in_ready, draining ? 0 : 1);
            if (!draining) chk("fill_out_valid", b0.out_valid, 0);
            if (draining && cyc == last_cyc + 1) chk("valid_t1", b0.out_valid, 0);
            if (draining && cyc == last_cyc + 2) chk("valid_t2", b0.out_valid, 1);
            if (stall_prev) begin
                chk("stall_valid", b0.out_valid, 1);
                chk("stall_data", b0.out_data, data_prev);
                chk("stall_last", b0.out_last, last_prev);
            end
            run = b0.out_valid ? run + 1 : 0;
            if (draining && b0.out_valid && b0.out_ready) begin
                chk("out_data", b0.out_data, frame[map_idx(out_idx, W, H, K, S)]);
                chk("out_last", b0.out_last, (out_idx == N - 1) ? 1 : 0);
                got.push_back(int'(b0.out_data));
                out_idx++;
                if (out_idx == N) begin
                    out_idx  = 0;
                    in_cnt   = 0;
                    last_run = run;
                    frames++;
                end
            end
            stall_prev = b0.out_valid && !b0.out_ready;
            data_prev  = b0.out_data;
            last_prev  = b0.out_last;
            if (!draining && b0.in_valid && b0.in_ready) begin
                frame[in_cnt] = int'(b0.in_data);
                in_cnt++;
                if (in_cnt == N) last_cyc = cyc;
            end
        end
    end

    always @(negedge clk) begin : mon1
        if (rst) begin
            idx1 = 0;
        end else if (b1.out_valid && b1.out_ready) begin
            chk("sweep_data", b1.out_data, map_idx(idx1, W1, H1, K1, S1));
            chk("sweep_last", b1.out_last, (idx1 == N1 - 1) ? 1 : 0);
            got1.push_back(int'(b1.out_data));
            idx1++;
            if (idx1 == N1) begin
                idx1 = 0;
                frames1++;
            end
        end
    end

    initial begin
        b0.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            b0.out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    task automatic feed(input int base, input int count, input bit gaps, input bit hold);
        int t;
        for (int i = 0; i < count; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                b0.in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            b0.in_valid = 1'b1;
            b0.in_data  = DW'(base + i);
            t = 0;
            @(negedge clk);
            while (!b0.in_ready && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (!b0.in_ready) begin
                timeout("feed");
                b0.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        if (!hold) b0.in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int t = 0;
        while (frames < target && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (frames < target) timeout("wait_frames");
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int exp_first [12];
        int exp_mid [4];
        int exp_tail [4];
        int exp_b2b [4];
        int f;
        int t;
        exp_first = '{0, 2, 8, 10, 16, 18, 24, 26, 32, 34, 40, 42};
        exp_mid   = '{1, 3, 9, 11};
        exp_tail  = '{37, 39, 45, 47};
        exp_b2b   = '{100, 102, 108, 110};

        b0.in_valid  = 1'b0;
        b0.in_data   = '0;
        b1.in_valid  = 1'b0;
        b1.in_data   = '0;
        b1.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic map with continuous out_ready
        got.delete();
        f = frames;
        feed(0, N, 1'b0, 1'b0);
        wait_frames(f + 1);
        chk("basic_count", got.size(), N);
        chk("basic_run", last_run, N);
        if (got.size() == N) begin
            for (int i = 0; i < 12; i++) chk("basic_first", got[i], exp_first[i]);
            for (int i = 0; i < 4; i++) chk("basic_mid", got[12 + i], exp_mid[i]);
            for (int i = 0; i < 4; i++) chk("basic_tail", got[44 + i], exp_tail[i]);
        end

        // Backpressure and input gaps
        ready_mode = 1;
        got.delete();
        f = frames;
        feed(0, N, 1'b1, 1'b0);
        wait_frames(f + 1);
        ready_mode = 0;
        chk("bp_count", got.size(), N);
        if (got.size() == N) begin
            for (int i = 0; i < 12; i++) chk("bp_first", got[i], exp_first[i]);
        end

        // Reset mid-fill, then mid-drain, then a clean frame
        feed(0, 20, 1'b0, 1'b0);
        pulse_rst();
        feed(0, N, 1'b0, 1'b0);
        t = 0;
        while (out_idx < 5 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (out_idx < 5) timeout("wait_outputs");
        #1;
        pulse_rst();
        got.delete();
        f = frames;
        feed(0, N, 1'b0, 1'b0);
        wait_frames(f + 1);
        chk("rst_recover_count", got.size(), N);
        if (got.size() == N) begin
            for (int i = 0; i < 12; i++) chk("rst_recover", got[i], exp_first[i]);
        end

        // Back-to-back frames with in_valid held high
        got.delete();
        f = frames;
        feed(0, N, 1'b0, 1'b1);
        feed(100, N, 1'b0, 1'b0);
        wait_frames(f + 2);
        chk("b2b_count", got.size(), 2 * N);
        if (got.size() == 2 * N) begin
            for (int i = 0; i < 4; i++) chk("b2b_second", got[N + i], exp_b2b[i]);
        end

        // Parameter sweep instance: input = index
        got1.delete();
        for (int i = 0; i < N1; i++) begin
            b1.in_valid = 1'b1;
            b1.in_data  = DW'(i);
            t = 0;
            @(negedge clk);
            while (!b1.in_ready && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (!b1.in_ready) begin
                timeout("sweep_feed");
                break;
            end
            @(posedge clk);
            #1;
        end
        b1.in_valid = 1'b0;
        t = 0;
        while (frames1 < 1 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (frames1 < 1) timeout("sweep_wait");
        #1;
        chk("sweep_count", got1.size(), N1);
        if (got1.size() == N1) begin
            // oc=1 (q0,c1) -> 32,36; oc=5 (q2,c1) -> x=2,6 in channel 1 -> 34,38
            chk("sweep_o0", got1[0], 0);
            chk("sweep_o1", got1[1], 4);
            chk("sweep_oc1a", got1[2], 32);
            chk("sweep_oc1b", got1[3], 36);
            chk("sweep_oc5a", got1[10], 34);
            chk("sweep_oc5b", got1[11], 38);
            chk("sweep_lastv", got1[N1 - 1], 63);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
